// File: rtl/adma_pkg.sv
// adma_pkg: shared definitions for the ADMA descriptor fetch stage and the
// control FSM that consumes its fields.
//   - fetch state encodings (also exported on fetch_state_o)
//   - descriptor geometry and beat indices of each field
//   - dc_fc subfield positions used by the control FSM
package adma_pkg;

    typedef enum logic [2:0] {
        ADMA_FS_IDLE  = 3'd0,
        ADMA_FS_FETCH = 3'd1,
        ADMA_FS_RETRY = 3'd2,
        ADMA_FS_DONE  = 3'd3,
        ADMA_FS_ERR   = 3'd4
    } adma_fs_e;

    // One descriptor is 32 bytes = 4 x 64-bit beats.
    localparam int DESC_BEATS = 4;

    // Beat that carries each field (fields live in the high word except ctl_adr).
    localparam logic [1:0] BEAT_NEXT_CTL = 2'd0;
    localparam logic [1:0] BEAT_DC_FC    = 2'd1;
    localparam logic [1:0] BEAT_SRC      = 2'd2;
    localparam logic [1:0] BEAT_DST      = 2'd3;

    // dc_fc subfields as interpreted by the control FSM.
    localparam int DCFC_LEN_LSB  = 0;
    localparam int DCFC_LEN_W    = 16;
    localparam int DCFC_CHK_LSB  = 16;
    localparam int DCFC_CHK_W    = 8;
    localparam int DCFC_LINK_BIT = 24;
    localparam int DCFC_INTR_BIT = 25;

    function automatic logic [DCFC_LEN_W-1:0] dcfc_len(input logic [31:0] dc_fc);
        return dc_fc[DCFC_LEN_LSB +: DCFC_LEN_W];
    endfunction

endpackage

// File: rtl/adma_desc_fetch.sv
// adma_desc_fetch: bursts one 32-byte descriptor (4 x 64-bit beats) over a
// Wishbone master port on start_i, splits it into fields and holds them
// (desc_valid_o) until desc_ack_i. Retry, error and abort are resolved here so
// the consumer only sees complete descriptors or the sticky desc_err_o.
//
// Optional feature macro: ADMA_FETCH_TIMEOUT_EN -- when defined, a beat that
// sees no ack/err/rty for TIMEOUT_CYC cycles of stb forces the error state.
//
// Ports:
//   wb_clk_i, wb_rst_i (async, active-high)
//   start_i, desc_adr_i, abort_i, desc_ack_i, err_clr_i  -- control in
//   busy_o, desc_valid_o, desc_err_o, fetch_state_o       -- status out
//   next_desc_o, ctl_adr_o, dc_fc_o, src_desc_o, dst_desc_o -- fields
//   wbm_*                                                 -- Wishbone master
module adma_desc_fetch
    import adma_pkg::*;
#(
    parameter int RETRY_MAX   = 7,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] desc_adr_i,
    input  logic        abort_i,
    input  logic        desc_ack_i,
    input  logic        err_clr_i,
    output logic        busy_o,
    output logic        desc_valid_o,
    output logic        desc_err_o,
    output logic [31:0] next_desc_o,
    output logic [31:0] ctl_adr_o,
    output logic [31:0] dc_fc_o,
    output logic [31:0] src_desc_o,
    output logic [31:0] dst_desc_o,
    output logic [7:0]  fetch_state_o,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_cab_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic [31:0] wbm_dat64_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    localparam int RETRY_W = $clog2(RETRY_MAX + 2);

    adma_fs_e           state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [1:0]         beat_q, beat_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               cab_q, cab_d;
    logic [31:0]        adr_q, adr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               fail;
    logic               cap_en;
    logic [31:0]        next_q, ctl_q, dcfc_q, src_q, dst_q;

`ifdef ADMA_FETCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_q, to_d;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) to_q <= '0;
        else          to_q <= to_d;
    end

    logic unused_adr_lsb;
    assign unused_adr_lsb = ^desc_adr_i[2:0];
`else
    logic unused_cfg;
    assign unused_cfg = ^{desc_adr_i[2:0], TIMEOUT_CYC[0]};
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        retry_d = retry_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        valid_d = valid_q;
        err_d   = err_q;
        fail    = 1'b0;
        cap_en  = 1'b0;
`ifdef ADMA_FETCH_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            ADMA_FS_IDLE: begin
                if (start_i) begin
                    base_d  = {desc_adr_i[31:3], 3'b000};
                    beat_d  = 2'd0;
                    retry_d = '0;
                    state_d = ADMA_FS_FETCH;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
`ifdef ADMA_FETCH_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            ADMA_FS_FETCH: begin
                // err outranks ack and rty presented in the same cycle.
                if (wbm_err_i) begin
                    fail = 1'b1;
                end else if (wbm_ack_i) begin
                    cap_en  = 1'b1;
                    retry_d = '0;
`ifdef ADMA_FETCH_TIMEOUT_EN
                    to_d    = '0;
`endif
                    if (beat_q == BEAT_DST) begin
                        state_d = ADMA_FS_DONE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        valid_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else if (wbm_rty_i) begin
`ifdef ADMA_FETCH_TIMEOUT_EN
                    to_d = '0;
`endif
                    // retry_q counts rty already seen on this beat.
                    if (retry_q == RETRY_W'(RETRY_MAX)) begin
                        fail = 1'b1;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ADMA_FS_RETRY;
                        stb_d   = 1'b0;
                    end
                end
`ifdef ADMA_FETCH_TIMEOUT_EN
                else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    fail = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            ADMA_FS_RETRY: begin
                state_d = ADMA_FS_FETCH;
                stb_d   = 1'b1;
            end
            ADMA_FS_DONE: begin
                if (desc_ack_i) begin
                    valid_d = 1'b0;
                    if (start_i) begin
                        base_d  = {desc_adr_i[31:3], 3'b000};
                        beat_d  = 2'd0;
                        retry_d = '0;
                        state_d = ADMA_FS_FETCH;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
`ifdef ADMA_FETCH_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end else begin
                        state_d = ADMA_FS_IDLE;
                    end
                end
            end
            ADMA_FS_ERR: begin
                if (err_clr_i) begin
                    state_d = ADMA_FS_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ADMA_FS_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase

        // Abort wins over everything except a latched error.
        if (abort_i && (state_q != ADMA_FS_ERR)) begin
            state_d = ADMA_FS_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            valid_d = 1'b0;
            err_d   = err_q;
            cap_en  = 1'b0;
        end else if (fail) begin
            state_d = ADMA_FS_ERR;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            valid_d = 1'b0;
            err_d   = 1'b1;
        end

        adr_d = base_d + {27'd0, beat_d, 3'b000};
        cab_d = stb_d && (beat_d != BEAT_DST);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ADMA_FS_IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            retry_q <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            cab_q   <= 1'b0;
            adr_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            retry_q <= retry_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            cab_q   <= cab_d;
            adr_q   <= adr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Field registers only change on an accepted beat, so they freeze in DONE
    // and keep partial contents after abort or error.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            next_q <= '0;
            ctl_q  <= '0;
            dcfc_q <= '0;
            src_q  <= '0;
            dst_q  <= '0;
        end else if (cap_en) begin
            case (beat_q)
                BEAT_NEXT_CTL: begin
                    next_q <= wbm_dat64_i;
                    ctl_q  <= wbm_dat_i;
                end
                BEAT_DC_FC: dcfc_q <= wbm_dat64_i;
                BEAT_SRC:   src_q  <= wbm_dat64_i;
                default:    dst_q  <= wbm_dat64_i;
            endcase
        end
    end

    assign busy_o        = (state_q == ADMA_FS_FETCH) || (state_q == ADMA_FS_RETRY);
    assign desc_valid_o  = valid_q;
    assign desc_err_o    = err_q;
    assign next_desc_o   = next_q;
    assign ctl_adr_o     = ctl_q;
    assign dc_fc_o       = dcfc_q;
    assign src_desc_o    = src_q;
    assign dst_desc_o    = dst_q;
    assign fetch_state_o = {5'd0, state_q};
    assign wbm_adr_o     = adr_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = stb_q;
    assign wbm_cab_o     = cab_q;
    assign wbm_we_o      = 1'b0;
    assign wbm_sel_o     = 4'b1111;

endmodule

// File: tb/tb_adma_desc_fetch.sv
module tb_adma_desc_fetch;
    import adma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, dack, eclr;
    logic [31:0] desc_adr;
    logic        busy, valid, derr;
    logic [31:0] f_next, f_ctl, f_dcfc, f_src, f_dst;
    logic [7:0]  fstate;
    logic [31:0] wadr;
    logic        wcyc, wstb, wcab, wwe;
    logic [3:0]  wsel;
    logic [31:0] wdat, wdat64;
    logic        wack, werr, wrty;

    always #5 clk = ~clk;

    adma_desc_fetch #(.RETRY_MAX(7), .TIMEOUT_CYC(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .desc_adr_i(desc_adr),
        .abort_i(abort), .desc_ack_i(dack), .err_clr_i(eclr), .busy_o(busy),
        .desc_valid_o(valid), .desc_err_o(derr), .next_desc_o(f_next),
        .ctl_adr_o(f_ctl), .dc_fc_o(f_dcfc), .src_desc_o(f_src), .dst_desc_o(f_dst),
        .fetch_state_o(fstate), .wbm_adr_o(wadr), .wbm_cyc_o(wcyc), .wbm_stb_o(wstb),
        .wbm_cab_o(wcab), .wbm_we_o(wwe), .wbm_sel_o(wsel), .wbm_dat_i(wdat),
        .wbm_dat64_i(wdat64), .wbm_ack_i(wack), .wbm_err_i(werr), .wbm_rty_i(wrty)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory / responder ----------------
    localparam int R_ACK = 0, R_RTY = 1, R_ERR = 2, R_ERRACK = 3, R_NONE = 4;
    int          resp_q[$];
    int          resp_default = R_ACK;
    logic [31:0] mem_lo[4];
    logic [31:0] mem_hi[4];

    always @(negedge clk) begin
        int code;
        wack = 1'b0; wrty = 1'b0; werr = 1'b0; wdat = '0; wdat64 = '0;
        if (wcyc && wstb) begin
            code   = (resp_q.size() > 0) ? resp_q.pop_front() : resp_default;
            wack   = (code == R_ACK) || (code == R_ERRACK);
            wrty   = (code == R_RTY);
            werr   = (code == R_ERR) || (code == R_ERRACK);
            wdat   = mem_lo[wadr[4:3]];
            wdat64 = mem_hi[wadr[4:3]];
        end
    end

    // ---------------- scoreboard ----------------
    localparam int K_BEAT = 0, K_DESC = 1, K_ERR = 2;
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic        c;
        logic [31:0] f0, f1, f2, f3, f4;
    } ev_t;
    ev_t exp_q[$];
    int  retry_seen = 0;

    task automatic push_beat(input logic [31:0] a, input logic c);
        ev_t e;
        e = '{K_BEAT, a, c, 0, 0, 0, 0, 0};
        exp_q.push_back(e);
    endtask

    task automatic push_burst(input logic [31:0] base);
        for (int i = 0; i < 4; i++) push_beat(base + 32'(i * 8), i != 3);
    endtask

    task automatic push_desc(input logic [31:0] n, c, d, s, t);
        ev_t e;
        e = '{K_DESC, 0, 1'b0, n, c, d, s, t};
        exp_q.push_back(e);
    endtask

    task automatic push_std_desc();
        push_desc(32'h300, 32'h200, 32'h1, 32'h400, 32'h500);
    endtask

    task automatic push_err();
        ev_t e;
        e = '{K_ERR, 0, 1'b0, 0, 0, 0, 0, 0};
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            ok = (kind == e.kind);
        end
    endtask

    initial begin
        logic pv, pe;
        ev_t  e;
        bit   ok;
        pv = 1'b0; pe = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (fstate == 8'(ADMA_FS_RETRY)) begin
                    chk("retry_cyc_stb", {30'd0, wcyc, wstb}, 32'b10);
                    retry_seen++;
                end
                if (wcyc && wstb && (wack || wrty || werr)) begin
                    take(K_BEAT, e, ok);
                    if (ok) begin
                        chk("beat_adr", wadr, e.a);
                        chk("beat_cab", {31'd0, wcab}, {31'd0, e.c});
                        $display("beat adr=0x%0h cab=%0b ack=%0b rty=%0b err=%0b", wadr, wcab, wack, wrty, werr);
                    end
                end
                if (valid && !pv) begin
                    take(K_DESC, e, ok);
                    if (ok) begin
                        chk("next_desc", f_next, e.f0);
                        chk("ctl_adr", f_ctl, e.f1);
                        chk("dc_fc", f_dcfc, e.f2);
                        chk("src_desc", f_src, e.f3);
                        chk("dst_desc", f_dst, e.f4);
                        $display("desc next=0x%0h ctl=0x%0h dcfc=0x%0h src=0x%0h dst=0x%0h", f_next, f_ctl, f_dcfc, f_src, f_dst);
                    end
                end
                if (derr && !pe) begin
                    take(K_ERR, e, ok);
                    if (ok) begin
                        chk("err_cyc", {31'd0, wcyc}, 32'd0);
                        chk("err_valid", {31'd0, valid}, 32'd0);
                        $display("error raised state=%0d", fstate);
                    end
                end
            end
            pv = valid; pe = derr;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input logic [31:0] a);
        @(negedge clk); start = 1'b1; desc_adr = a;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!valid && n < 64) begin @(negedge clk); n++; end
        if (!valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_err();
        int n;
        n = 0;
        while (!derr && n < 100) begin @(negedge clk); n++; end
        if (!derr) chk("err_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_desc();
        @(negedge clk); dack = 1'b1;
        @(negedge clk); dack = 1'b0;
        #1 chk("state_after_ack", 32'(fstate), 32'(ADMA_FS_IDLE));
    endtask

    task automatic clear_err();
        @(negedge clk); eclr = 1'b1;
        @(negedge clk); eclr = 1'b0;
        #1;
        chk("state_after_clr", 32'(fstate), 32'(ADMA_FS_IDLE));
        chk("err_after_clr", {31'd0, derr}, 32'd0);
    endtask

    initial begin
        int n;
        mem_hi = '{32'h300, 32'h1, 32'h400, 32'h500};
        mem_lo = '{32'h200, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
        rst = 1'b1; start = 0; abort = 0; dack = 0; eclr = 0; desc_adr = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, wcyc}, 0);
        chk("rst_stb", {31'd0, wstb}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_err", {31'd0, derr}, 0);
        chk("rst_state", 32'(fstate), 0);
        chk("rst_adr", wadr, 0);
        chk("rst_next", f_next, 0);
        @(negedge clk); rst = 1'b0;

        // 1: zero-wait burst at 0
        push_burst(32'h0); push_std_desc();
        pulse_start(32'h0);
        chk("busy_fetch", {31'd0, busy}, 1);
        wait_valid(n);
        chk("valid_cycle", 32'(n), 5);
        ack_desc();

        // 2: unaligned address
        push_burst(32'h200); push_std_desc();
        pulse_start(32'h207);
        chk("first_adr", wadr, 32'h200);
        wait_valid(n);
        ack_desc();

        // 3a: two retries on beat 1
        retry_seen = 0;
        resp_q = '{R_ACK, R_RTY, R_RTY, R_ACK, R_ACK, R_ACK};
        push_beat(32'h0, 1); push_beat(32'h8, 1); push_beat(32'h8, 1);
        push_beat(32'h8, 1); push_beat(32'h10, 1); push_beat(32'h18, 0);
        push_std_desc();
        pulse_start(32'h0);
        wait_valid(n);
        chk("retry_cycles", 32'(retry_seen), 2);
        ack_desc();

        // 3b: eight retries on beat 1 -> error
        retry_seen = 0;
        resp_q = '{R_ACK, R_RTY, R_RTY, R_RTY, R_RTY, R_RTY, R_RTY, R_RTY, R_RTY};
        push_beat(32'h0, 1);
        for (int i = 0; i < 8; i++) push_beat(32'h8, 1);
        push_err();
        pulse_start(32'h0);
        wait_err();
        chk("rty_err_cyc", {31'd0, wcyc}, 0);
        chk("rty_retry_cycles", 32'(retry_seen), 7);
        clear_err();

        // 4: err with ack on beat 2, start ignored in ERR
        resp_q = '{R_ACK, R_ACK, R_ERRACK};
        push_beat(32'h0, 1); push_beat(32'h8, 1); push_beat(32'h10, 1); push_err();
        pulse_start(32'h0);
        wait_err();
        pulse_start(32'h40);
        repeat (3) @(negedge clk);
        #1;
        chk("err_state_hold", 32'(fstate), 32'(ADMA_FS_ERR));
        chk("err_no_cyc", {31'd0, wcyc}, 0);
        chk("err_no_valid", {31'd0, valid}, 0);
        clear_err();

        // 5a: abort during beat 2, partial fields kept
        mem_hi[0] = 32'h3A0;
        resp_default = R_NONE;
        resp_q = '{R_ACK, R_ACK};
        push_beat(32'h0, 1); push_beat(32'h8, 1);
        pulse_start(32'h0);
        n = 0;
        while (!(wstb && wadr == 32'h10) && n < 20) begin @(negedge clk); n++; end
        chk("beat2_reached", {31'd0, wstb && wadr == 32'h10}, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        #1;
        chk("abort_cyc", {31'd0, wcyc}, 0);
        chk("abort_state", 32'(fstate), 0);
        chk("abort_valid", {31'd0, valid}, 0);
        chk("abort_next_kept", f_next, 32'h3A0);
        chk("abort_src_old", f_src, 32'h400);
        mem_hi[0] = 32'h300;
        resp_default = R_ACK;

        // 5b: ack+start in DONE -> immediate fetch at 0x100
        push_burst(32'h0); push_std_desc();
        push_burst(32'h100); push_std_desc();
        pulse_start(32'h0);
        wait_valid(n);
        @(negedge clk); dack = 1'b1; start = 1'b1; desc_adr = 32'h100;
        @(negedge clk); dack = 1'b0; start = 1'b0;
        #1;
        chk("chain_valid", {31'd0, valid}, 0);
        chk("chain_cyc", {31'd0, wcyc}, 1);
        chk("chain_adr", wadr, 32'h100);
        chk("chain_state", 32'(fstate), 32'(ADMA_FS_FETCH));
        wait_valid(n);
        ack_desc();

        // 6: withheld ack
        resp_default = R_NONE;
`ifdef ADMA_FETCH_TIMEOUT_EN
        push_err();
        pulse_start(32'h0);
        n = 0;
        for (int k = 0; k < 200 && !derr; k++) begin
            if (wstb) n++;
            @(negedge clk);
        end
        chk("timeout_stb_cycles", 32'(n), 16);
        chk("timeout_err", {31'd0, derr}, 1);
        clear_err();
`else
        pulse_start(32'h0);
        repeat (500) @(negedge clk);
        chk("no_timeout_state", 32'(fstate), 32'(ADMA_FS_FETCH));
        chk("no_timeout_stb", {31'd0, wstb}, 1);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        #1 chk("no_timeout_abort", 32'(fstate), 0);
`endif

        // 7: asynchronous reset mid-burst
        pulse_start(32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cyc", {31'd0, wcyc}, 0);
        chk("async_rst_state", 32'(fstate), 0);
        @(negedge clk); rst = 1'b0;
        resp_default = R_ACK;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
